// File: rtl/display_scan_ctrl.sv
// Credit readout driver: sequential binary-to-BCD conversion into a display buffer,
// then 4-digit multiplexed scan with leading-zero blanking and a fixed decimal point.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        lzb,
  output logic        busy,
  output logic        err,
  output logic [3:0]  x,
  output logic [3:0]  AN,
  output logic        DP
);

  localparam int          RW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
  localparam logic [1:0]  DP_IDX  = 2'(DP_POS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nx;
  logic [29:0]   sr;        // {bcd[15:0], binary[13:0]}
  logic [29:0]   sr_adj;
  logic [3:0]    cnt;
  logic [15:0]   dbuf;
  logic [RW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    blank;
  logic          allz;
  logic          accept;

  assign accept = (state == IDLE) && load;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load) state_nx = SHIFT;
      end
      SHIFT:   if (cnt == 4'd13) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 4; k++) begin
      if (sr[14+4*k +: 4] >= 4'd5) sr_adj[14+4*k +: 4] = sr[14+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      err  <= 1'b0;
      dbuf <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sr  <= {16'd0, (value > 14'd9999) ? 14'd9999 : value};
          err <= (value > 14'd9999);
          cnt <= '0;
        end
        SHIFT: begin
          sr  <= {sr_adj[28:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
        DONE:    dbuf <= sr[29:14];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RLAST) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // A digit blanks only above the decimal point and when it and all higher digits are zero.
  always_comb begin
    blank = '0;
    allz  = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      allz     = allz & (dbuf[4*i +: 4] == 4'd0);
      blank[i] = lzb && (i > DP_POS) && allz;
    end
  end

  assign x  = dbuf[{idx, 2'b00} +: 4];
  assign AN = blank[idx] ? 4'b1111 : ~(4'b0001 << idx);
  assign DP = (idx == DP_IDX) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=4, DP_POS=2.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        lzb;
  logic        busy, err, DP;
  logic [3:0]  x, AN;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // cycles since last reset, drives the expected scan index

  display_scan_ctrl #(.REFRESH_DIV(4), .DP_POS(2)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .lzb(lzb),
    .busy(busy), .err(err), .x(x), .AN(AN), .DP(DP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else     cyc++;
  endtask

  function automatic int eidx();
    return (cyc / 4) % 4;
  endfunction

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic goto_idx(input int k);
    while (eidx() != k) tick();
  endtask

  task automatic do_load(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_digits(input string tag, input logic [15:0] exp);
    for (int k = 0; k < 4; k++) begin
      goto_idx(k);
      chk({tag, "_x"}, x, exp[4*k +: 4]);
    end
  endtask

  initial begin
    int n;
    logic [15:0] v1234;
    rst = 1'b1; value = '0; load = 1'b0; lzb = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_err",  err,  0);
    chk("rst_an",   AN,   4'b1110);
    chk("rst_x",    x,    0);
    chk("rst_dp",   DP,   1);
    rst = 1'b0;

    // scan sequence over one full frame plus the wrap
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("scan_an", AN, an_of(eidx()));
      chk("scan_dp", DP, (eidx() == 2) ? 0 : 1);
    end

    do_load(14'd1234);
    chk("ld_busy", busy, 1);
    chk("ld_oldx", x, 0);
    wait_done(n);
    chk("busy_len", n, 15);
    chk("err_1234", err, 0);
    v1234 = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      goto_idx(k);
      chk("d1234_x",  x,  v1234[4*k +: 4]);
      chk("d1234_an", AN, an_of(k));
    end

    lzb = 1'b1;
    do_load(14'd42);
    wait_done(n);
    goto_idx(3);
    chk("lzb_an3", AN, 4'b1111);
    chk("lzb_x3",  x,  0);
    goto_idx(0);
    chk("lzb_x0",  x,  2);
    goto_idx(1);
    chk("lzb_x1",  x,  4);
    goto_idx(2);
    chk("lzb_x2",  x,  0);
    chk("lzb_an2", AN, 4'b1011);
    chk("lzb_dp2", DP, 0);
    lzb = 1'b0;
    goto_idx(3);
    chk("nolzb_an3", AN, 4'b0111);

    do_load(14'd12000);
    wait_done(n);
    chk("ovf_err", err, 1);
    chk_digits("ovf", 16'h9999);

    do_load(14'd5);
    chk("reload_busy", busy, 1);
    wait_done(n);
    do_load(14'd5);               // first IDLE cycle after DONE
    chk("idle_accept", busy, 1);
    wait_done(n);
    chk("five_err", err, 0);
    chk_digits("five", 16'h0005);
    goto_idx(1);
    chk("five_an1", AN, 4'b1101);

    do_load(14'd1234);
    for (int i = 0; i < 4; i++) tick();
    do_load(14'd777);             // lands in busy cycle 5, dropped
    wait_done(n);
    chk("drop_len", n, 10);
    tick();
    chk("drop_idle", busy, 0);
    chk_digits("drop", 16'h1234);

    do_load(14'd777);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_x",    x,    0);
    chk("abort_an",   AN,   4'b1110);
    chk_digits("abort", 16'h0000);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_stay", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
